// File: rtl/nms_sequencer.sv
// nms_sequencer: greedy non-maximum-suppression control FSM driving a kept-box buffer and an IoU unit.
// Optional feature: define NMS_EARLY_EXIT_EN to end a run at the first under-threshold candidate.
//
// state | meaning
// IDLE  | waiting for start; results of the last run held
// FETCH | pred_ready high, waiting for the next candidate
// ISSUE | one kept-buffer read per cycle, addresses 0..kept_count-1
// DRAIN | collecting the remaining IoU responses, then deciding
// WRITE | append the candidate to the kept buffer
// DONE  | one-cycle done pulse
module nms_sequencer #(
    parameter int BBOX_IND_WIDTH = 14,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int S_WIDTH        = 16,
    parameter int READ_LAT       = 8,
    parameter int MAX_KEEP       = 2**MEM_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [BBOX_IND_WIDTH-1:0] num_pred,
    input  logic [S_WIDTH-1:0]        S_thresh,
    input  logic                      pred_valid,
    output logic                      pred_ready,
    input  logic [S_WIDTH-1:0]        pred_S,
    input  logic                      iou_valid,
    input  logic                      iou_suppress,
    output logic                      rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] bbox_raddr,
    output logic                      wr_en,
    output logic [MEM_ADDR_WIDTH-1:0] bbox_waddr,
    output logic [BBOX_IND_WIDTH-1:0] cand_idx,
    output logic [MEM_ADDR_WIDTH:0]   kept_count,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);

    localparam int KW = MEM_ADDR_WIDTH + 1;
    localparam logic [KW-1:0] MAX_KEEP_C = KW'(MAX_KEEP);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_read_lat
        $error("nms_sequencer: READ_LAT must be in 1..15");
    end
    if (MAX_KEEP < 1 || MAX_KEEP > 2**MEM_ADDR_WIDTH) begin : g_bad_max_keep
        $error("nms_sequencer: MAX_KEEP must be in 1..2**MEM_ADDR_WIDTH");
    end

    logic [2:0]                state_q, state_d;
    logic [BBOX_IND_WIDTH-1:0] cand_idx_q, cand_idx_d;
    logic [BBOX_IND_WIDTH-1:0] num_pred_q, num_pred_d;
    logic [S_WIDTH-1:0]        s_thresh_q, s_thresh_d;
    logic [KW-1:0]             kept_count_q, kept_count_d;
    logic [KW-1:0]             issue_cnt_q, issue_cnt_d;
    logic [KW-1:0]             resp_cnt_q, resp_cnt_d;
    logic                      supp_flag_q, supp_flag_d;
    logic                      overflow_q, overflow_d;

    logic          resp_hit;
    logic [KW-1:0] resp_total;
    logic          supp_now;
    logic          advance;

    // Responses beyond kept_count, or outside ISSUE/DRAIN, never reach the counter.
    assign resp_hit   = iou_valid && (state_q == S_ISSUE || state_q == S_DRAIN)
                        && (resp_cnt_q < kept_count_q);
    assign resp_total = resp_cnt_q + KW'(resp_hit);
    assign supp_now   = supp_flag_q | (resp_hit & iou_suppress);

    always_comb begin
        state_d      = state_q;
        cand_idx_d   = cand_idx_q;
        num_pred_d   = num_pred_q;
        s_thresh_d   = s_thresh_q;
        kept_count_d = kept_count_q;
        issue_cnt_d  = issue_cnt_q;
        resp_cnt_d   = resp_total;
        supp_flag_d  = supp_now;
        overflow_d   = overflow_q;
        advance      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cand_idx_d   = '0;
                    kept_count_d = '0;
                    overflow_d   = 1'b0;
                    num_pred_d   = num_pred;
                    s_thresh_d   = S_thresh;
                    state_d      = (num_pred == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                issue_cnt_d = '0;
                resp_cnt_d  = '0;
                supp_flag_d = 1'b0;
                if (pred_valid) begin
                    if (s_thresh_q > pred_S) begin
`ifdef NMS_EARLY_EXIT_EN
                        cand_idx_d = cand_idx_q + 1'b1;
                        state_d    = S_DONE;
`else
                        advance = 1'b1;
`endif
                    end else if (kept_count_q == '0) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                issue_cnt_d = issue_cnt_q + 1'b1;
                if (issue_cnt_q + 1'b1 == kept_count_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (resp_total == kept_count_q) begin
                    if (supp_now) advance = 1'b1;
                    else          state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                kept_count_d = kept_count_q + 1'b1;
                advance      = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Overflow only flags a run cut short while candidates remained.
        if (advance) begin
            cand_idx_d = cand_idx_q + 1'b1;
            if (cand_idx_d == num_pred_q) begin
                state_d = S_DONE;
            end else if (kept_count_d == MAX_KEEP_C) begin
                state_d    = S_DONE;
                overflow_d = 1'b1;
            end else begin
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cand_idx_q   <= '0;
            num_pred_q   <= '0;
            s_thresh_q   <= '0;
            kept_count_q <= '0;
            issue_cnt_q  <= '0;
            resp_cnt_q   <= '0;
            supp_flag_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_idx_q   <= cand_idx_d;
            num_pred_q   <= num_pred_d;
            s_thresh_q   <= s_thresh_d;
            kept_count_q <= kept_count_d;
            issue_cnt_q  <= issue_cnt_d;
            resp_cnt_q   <= resp_cnt_d;
            supp_flag_q  <= supp_flag_d;
            overflow_q   <= overflow_d;
        end
    end

    assign pred_ready = (state_q == S_FETCH);
    assign rd_en      = (state_q == S_ISSUE);
    assign bbox_raddr = rd_en ? issue_cnt_q[MEM_ADDR_WIDTH-1:0] : '0;
    assign wr_en      = (state_q == S_WRITE);
    assign bbox_waddr = wr_en ? kept_count_q[MEM_ADDR_WIDTH-1:0] : '0;
    assign cand_idx   = cand_idx_q;
    assign kept_count = kept_count_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign overflow   = overflow_q;

endmodule

// File: doc/nms_sequencer.md
NMS_SEQUENCER -- requirements
Module: nms_sequencer
Interface
REQ-001 Parameters, one per line: name, default, meaning.
 BBOX_IND_WIDTH  14  prediction index width.
 MEM_ADDR_WIDTH  10  kept-box buffer address width.
 S_WIDTH  16  score width; IEEE-754 half, non-negative.
 READ_LAT  8  cycles from rd_en to iou_valid; legal range 1..15.
 MAX_KEEP  2**MEM_ADDR_WIDTH  kept-buffer capacity; legal range 1..2**MEM_ADDR_WIDTH.
REQ-002 Ports, one per line: name, direction, width, meaning.
 clk  in  1  single clock; all logic rising-edge.
 resetn  in  1  asynchronous, active-low reset.
 start  in  1  pulse; begins a run when idle.
 num_pred  in  BBOX_IND_WIDTH  number of predictions; sampled on accepted start.
 S_thresh  in  S_WIDTH  score threshold; sampled on accepted start.
 pred_valid  in  1  candidate available.
 pred_ready  out  1  candidate accepted on pred_valid&&pred_ready.
 pred_S  in  S_WIDTH  candidate score.
 iou_valid  in  1  IoU result strobe.
 iou_suppress  in  1  candidate overlaps the kept box above the IoU limit.
 rd_en  out  1  kept-buffer read strobe.
 bbox_raddr  out  MEM_ADDR_WIDTH  kept-buffer read address.
 wr_en  out  1  kept-buffer write strobe; writes the latched candidate.
 bbox_waddr  out  MEM_ADDR_WIDTH  kept-buffer write address.
 cand_idx  out  BBOX_IND_WIDTH  index of current candidate.
 kept_count  out  MEM_ADDR_WIDTH+1  boxes kept this run.
 busy  out  1  high outside IDLE and DONE.
 done  out  1  one-cycle pulse at run end.
 overflow  out  1  sticky; run ended because kept_count reached MAX_KEEP.
Function
REQ-003 FSM states SHALL be IDLE, FETCH, ISSUE, DRAIN, WRITE, DONE.
REQ-004 IDLE: start SHALL clear cand_idx, kept_count and overflow and go to FETCH; num_pred==0 goes to DONE instead; start outside IDLE SHALL be ignored.
REQ-005 FETCH: pred_ready SHALL be high only in FETCH; on accept, the candidate is under threshold when S_thresh>pred_S as unsigned S_WIDTH integers.
REQ-006 FETCH accept of an above-threshold candidate SHALL go to WRITE if kept_count==0, else to ISSUE.
REQ-007 ISSUE: rd_en SHALL be high every cycle with bbox_raddr=0,1,...,kept_count-1, one per cycle, then go to DRAIN.
REQ-008 The block SHALL OR every iou_suppress sampled with iou_valid into a per-candidate flag and count responses; when the count equals kept_count, the decision SHALL be taken.
REQ-009 Decision: flag clear goes to WRITE; flag set discards the candidate and advances.
REQ-010 WRITE SHALL hold wr_en high one cycle with bbox_waddr=kept_count, then increment kept_count.
REQ-011 Advance SHALL increment cand_idx and then go to DONE if cand_idx==num_pred or kept_count==MAX_KEEP (overflow set), else to FETCH.
REQ-012 DONE SHALL pulse done for one cycle and return to IDLE; kept_count and overflow SHALL hold until the next accepted start.
REQ-013 iou_valid outside ISSUE/DRAIN SHALL be ignored; a response count exceeding kept_count is an environment error and is ignored.
REQ-014 Per-candidate latency SHALL be 1 cycle (FETCH) + kept_count (ISSUE) + READ_LAT (DRAIN) + 1 (WRITE, if kept).
Reset
REQ-015 resetn low SHALL immediately force IDLE and clear every output and register to 0, including overflow.
REQ-016 Reset mid-run SHALL abandon the run without a done pulse or further rd_en/wr_en.
Configuration
REQ-017 With NMS_EARLY_EXIT_EN defined, an under-threshold candidate SHALL end the run (to DONE after cand_idx increments), relying on descending-sorted input.
REQ-018 Without NMS_EARLY_EXIT_EN, an under-threshold candidate SHALL be discarded and the run SHALL advance per REQ-011.
Verification
REQ-019 num_pred=3, all scores 0x3C00, thresh 0x3800, no suppress -> wr_en at waddr 0,1,2; kept_count=3; one done pulse.
REQ-020 num_pred=4, suppress asserted for candidate 2 only -> waddr 0,1,2 written; candidate 2 discarded; kept_count=3.
REQ-021 Scores 0x3C00,0x3400,0x3C00, thresh 0x3800 -> with NMS_EARLY_EXIT_EN kept_count=1, done after cand_idx=2; without, kept_count=2.
REQ-022 MAX_KEEP=2, num_pred=5, no suppress -> kept_count=2, overflow=1, done after second write.
REQ-023 resetn low during DRAIN -> outputs 0 at once, no done; a subsequent start runs normally from cand_idx 0.
